// File: rtl/mempool_pkg.sv
// Shared MemPool definitions used by the wake-up controller.
package mempool_pkg;

  // Target id that asks for every core to be woken.
  localparam logic [31:0] WakeupBroadcastId = 32'hFFFF_FFFF;

  // Wake-up controller FSM: either serving pending bits or sweeping a broadcast.
  typedef enum logic {
    WakeIdle,
    WakeBcast
  } wake_state_e;

endpackage

// File: rtl/mempool_wakeup_grp_sel.sv
// Combinational round-robin group picker for the wake-up controller.
// The any-pending vector is rotated so that group rr_ptr_i sits at bit 0;
// the count of clear bits below the first set bit is the offset of the
// winner from rr_ptr_i.
module mempool_wakeup_grp_sel #(
  parameter int unsigned NumGroups = 4,
  localparam int unsigned IdxW = (NumGroups > 1) ? $clog2(NumGroups) : 1
) (
  input  logic [NumGroups-1:0] grp_any_i,
  input  logic [IdxW-1:0]      rr_ptr_i,
  output logic [IdxW-1:0]      sel_o,
  output logic                 sel_valid_o
);

  logic [2*NumGroups-1:0] doubled;
  logic [NumGroups-1:0]   rotated;
  logic [IdxW-1:0]        offset;
  logic [IdxW+1:0]        sum;

  // Rotate, count zeros from the rr_ptr end, then map the offset back to a group index.
  always_comb begin
    doubled = {grp_any_i, grp_any_i};
    rotated = NumGroups'(doubled >> rr_ptr_i);
    offset  = '0;
    // Scanning from the top means the lowest set bit is the last one written.
    for (int i = NumGroups - 1; i >= 0; i--) begin
      if (rotated[i]) offset = IdxW'(i);
    end
    sel_valid_o = |rotated;
    sum = (IdxW+2)'(rr_ptr_i) + (IdxW+2)'(offset);
    if (sum >= (IdxW+2)'(NumGroups)) sum = sum - (IdxW+2)'(NumGroups);
    sel_o = sum[IdxW-1:0];
  end

endmodule

// File: rtl/mempool_wakeup_ctrl.sv
// Wake-up pulse sequencer for the MemPool cluster's wake_up_i vector.
// Requests (single core or broadcast) arrive over a valid/ready handshake;
// pulses leave one core group per cycle so the whole cluster never wakes at once.
// Optional build macro: MEMPOOL_WAKEUP_STATS_EN adds pulse/drop counters.
//
// Handshake: a request is taken on any cycle where wake_req_valid_i and
// wake_req_ready_o are both high; the target is sampled in that cycle.
// Ready is high whenever the FSM is idle, independent of valid.
module mempool_wakeup_ctrl
  import mempool_pkg::*;
#(
  parameter int unsigned NumCores  = 256,
  parameter int unsigned NumGroups = 4,
  parameter int unsigned GroupSize = NumCores / NumGroups
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wake_req_valid_i,
  output logic                wake_req_ready_o,
  input  logic [31:0]         wake_req_target_i,
  output logic [NumCores-1:0] wake_up_o,
  output logic                busy_o
`ifdef MEMPOOL_WAKEUP_STATS_EN
  ,
  input  logic                stats_clr_i,
  output logic [31:0]         pulse_cnt_o,
  output logic [31:0]         drop_cnt_o
`endif
);

  localparam int unsigned CoreIdxW = (NumCores > 1) ? $clog2(NumCores) : 1;
  localparam int unsigned GrpIdxW  = (NumGroups > 1) ? $clog2(NumGroups) : 1;
  localparam logic [GrpIdxW-1:0] LastGrp = GrpIdxW'(NumGroups - 1);

  if (NumCores % NumGroups != 0) begin : g_bad_cfg
    $error("NumCores must be a multiple of NumGroups");
  end

  // Bit mask covering every core of group g.
  function automatic logic [NumCores-1:0] grp_mask(input logic [GrpIdxW-1:0] g);
    logic [NumCores-1:0] m;
    m = '0;
    for (int c = 0; c < NumCores; c++) begin
      if ((c / GroupSize) == int'(g)) m[c] = 1'b1;
    end
    return m;
  endfunction

  wake_state_e         state_q, state_d;
  logic [NumCores-1:0] pending_q, pending_d;
  logic [GrpIdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [GrpIdxW-1:0]  grp_cnt_q, grp_cnt_d;
  logic [NumCores-1:0] wake_up_q, wake_up_d;

  logic [NumGroups-1:0] grp_any;
  logic [GrpIdxW-1:0]   sel;
  logic                 sel_valid;
  logic                 req_fire, req_bcast, req_core, req_drop;

  // Collapse pending bits into one flag per group for the picker.
  always_comb begin
    grp_any = '0;
    for (int g = 0; g < NumGroups; g++) begin
      grp_any[g] = |pending_q[g*GroupSize +: GroupSize];
    end
  end

  mempool_wakeup_grp_sel #(
    .NumGroups (NumGroups)
  ) i_grp_sel (
    .grp_any_i   (grp_any),
    .rr_ptr_i    (rr_ptr_q),
    .sel_o       (sel),
    .sel_valid_o (sel_valid)
  );

  // Next-state, pulse selection and request decode.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rr_ptr_d  = rr_ptr_q;
    grp_cnt_d = grp_cnt_q;
    wake_up_d = '0;

    wake_req_ready_o = (state_q == WakeIdle);
    req_fire  = wake_req_valid_i & wake_req_ready_o;
    req_bcast = req_fire & (wake_req_target_i == WakeupBroadcastId);
    req_core  = req_fire & (wake_req_target_i < 32'(NumCores));
    req_drop  = req_fire & ~req_bcast & ~req_core;

    case (state_q)
      WakeIdle: begin
        if (sel_valid) begin
          wake_up_d = pending_q & grp_mask(sel);
          pending_d = pending_q & ~grp_mask(sel);
          rr_ptr_d  = (sel == LastGrp) ? '0 : sel + GrpIdxW'(1);
        end
        if (req_bcast) begin
          state_d   = WakeBcast;
          grp_cnt_d = '0;
        end
      end
      WakeBcast: begin
        // The sweep covers every core, so pending bits are simply absorbed.
        wake_up_d = grp_mask(grp_cnt_q);
        pending_d = pending_q & ~grp_mask(grp_cnt_q);
        if (grp_cnt_q == LastGrp) begin
          grp_cnt_d = '0;
          state_d   = WakeIdle;
        end else begin
          grp_cnt_d = grp_cnt_q + GrpIdxW'(1);
        end
      end
      default: state_d = WakeIdle;
    endcase

    // Applied after the clear so a request landing on its group's pulse cycle survives.
    if (req_core) pending_d[wake_req_target_i[CoreIdxW-1:0]] = 1'b1;
  end

  // Controller state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= WakeIdle;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      grp_cnt_q <= '0;
      wake_up_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      grp_cnt_q <= grp_cnt_d;
      wake_up_q <= wake_up_d;
    end
  end

  assign wake_up_o = wake_up_q;
  assign busy_o    = (state_q != WakeIdle) | (|pending_q);

`ifdef MEMPOOL_WAKEUP_STATS_EN
  logic [31:0] pulse_cnt_q, pulse_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  // Counters wrap naturally; a clear overrides a same-cycle increment.
  always_comb begin
    pulse_cnt_d = pulse_cnt_q + {31'd0, |wake_up_q};
    drop_cnt_d  = drop_cnt_q + {31'd0, req_drop};
    if (stats_clr_i) begin
      pulse_cnt_d = '0;
      drop_cnt_d  = '0;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pulse_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      pulse_cnt_q <= pulse_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign pulse_cnt_o = pulse_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mempool_wakeup_ctrl.sv
// Self-checking bench for mempool_wakeup_ctrl (NumCores=16, NumGroups=4).
// Build with MEMPOOL_WAKEUP_STATS_EN defined to also check the counters.
module tb_mempool_wakeup_ctrl;

  localparam int NC = 16;
  localparam int NG = 4;
  localparam int GS = NC / NG;

  // Clock and reset
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          valid     = 1'b0;
  logic [31:0]   target    = '0;
  logic          stats_clr = 1'b0;
  logic          ready;
  logic [NC-1:0] wake;
  logic          busy;
  logic [31:0]   pulse_cnt, drop_cnt;

  int checks = 0;
  int errors = 0;

  mempool_wakeup_ctrl #(
    .NumCores  (NC),
    .NumGroups (NG)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .wake_req_valid_i  (valid),
    .wake_req_ready_o  (ready),
    .wake_req_target_i (target),
    .wake_up_o         (wake),
    .busy_o            (busy)
`ifdef MEMPOOL_WAKEUP_STATS_EN
    ,
    .stats_clr_i       (stats_clr),
    .pulse_cnt_o       (pulse_cnt),
    .drop_cnt_o        (drop_cnt)
`endif
  );

`ifndef MEMPOOL_WAKEUP_STATS_EN
  assign pulse_cnt = '0;
  assign drop_cnt  = '0;
`endif

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: pending set per core, broadcast sweep counter, rr pointer
  bit            m_pend[NC];
  int            m_rr      = 0;
  bit            m_bc      = 1'b0;
  int            m_bc_grp  = 0;
  logic [NC-1:0] exp_wake  = '0;
  bit            exp_ready = 1'b1;
  bit            exp_busy  = 1'b0;
  logic [31:0]   exp_pulse = '0;
  logic [31:0]   exp_drop  = '0;
  bit            cmp_en    = 1'b0;

  function automatic bit grp_has(input int g);
    bit r;
    r = 1'b0;
    for (int c = g * GS; c < (g + 1) * GS; c++) if (m_pend[c]) r = 1'b1;
    return r;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    logic [NC-1:0] nxt;
    int            found;
    bit            any;
    if (!rst_ni) begin
      for (int c = 0; c < NC; c++) m_pend[c] = 1'b0;
      m_rr = 0; m_bc = 1'b0; m_bc_grp = 0;
      exp_wake = '0; exp_ready = 1'b1; exp_busy = 1'b0;
      exp_pulse = '0; exp_drop = '0;
    end else begin
      nxt = '0;
      if (stats_clr) exp_pulse = '0;
      else if (exp_wake != '0) exp_pulse = exp_pulse + 1;
      if (stats_clr) exp_drop = '0;
      if (m_bc) begin
        for (int c = m_bc_grp * GS; c < (m_bc_grp + 1) * GS; c++) begin
          nxt[c] = 1'b1;
          m_pend[c] = 1'b0;
        end
        m_bc_grp++;
        if (m_bc_grp == NG) begin
          m_bc = 1'b0;
          m_bc_grp = 0;
        end
        // Broadcast ended this edge; acceptance depended on the state before it.
        if (valid && !stats_clr) ; // nothing accepted while sweeping
      end else begin
        found = -1;
        for (int k = 0; k < NG; k++) begin
          if (found < 0 && grp_has((m_rr + k) % NG)) found = (m_rr + k) % NG;
        end
        if (found >= 0) begin
          for (int c = found * GS; c < (found + 1) * GS; c++) begin
            nxt[c] = m_pend[c];
            m_pend[c] = 1'b0;
          end
          m_rr = (found + 1) % NG;
        end
        if (valid) begin
          if (target == 32'hFFFF_FFFF) begin
            m_bc = 1'b1;
            m_bc_grp = 0;
          end else if (target < NC) begin
            m_pend[target] = 1'b1;
          end else if (!stats_clr) begin
            exp_drop = exp_drop + 1;
          end
        end
      end
      any = 1'b0;
      for (int c = 0; c < NC; c++) if (m_pend[c]) any = 1'b1;
      exp_wake  = nxt;
      exp_ready = !m_bc;
      exp_busy  = m_bc || any;
    end
  end

  // Scoreboard compare every cycle
  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("model_wake", wake, exp_wake);
      chk("model_ready", ready, exp_ready);
      chk("model_busy", busy, exp_busy);
`ifdef MEMPOOL_WAKEUP_STATS_EN
      chk("model_pulse_cnt", pulse_cnt, exp_pulse);
      chk("model_drop_cnt", drop_cnt, exp_drop);
`endif
    end
  end

  // Driver: one request accepted at the next edge; returns at the following negedge
  task automatic send(input logic [31:0] t);
    valid = 1'b1;
    target = t;
    @(posedge clk_i);
    @(negedge clk_i);
    valid = 1'b0;
  endtask

  logic [15:0] bc_pat[4];
  logic [31:0] t4_tgt[3];
  logic [15:0] t4_exp[3];
  int          r;

  initial begin
    bc_pat = '{16'h000F, 16'h00F0, 16'h0F00, 16'hF000};
    t4_tgt = '{32'd1, 32'd9, 32'd13};
    t4_exp = '{16'h0002, 16'h0200, 16'h2000};

    repeat (3) @(negedge clk_i);
    chk("reset_wake", wake, 16'h0000);
    chk("reset_ready", ready, 1);
    rst_ni = 1'b1;
    cmp_en = 1'b1;

    // Idle after reset
    repeat (20) begin
      @(negedge clk_i);
      chk("idle_wake", wake, 16'h0000);
      chk("idle_busy", busy, 0);
      chk("idle_ready", ready, 1);
    end

    // Out-of-range requests are accepted and dropped
    send(32'd20);
    chk("drop_ready", ready, 1);
    send(32'h1234);
    repeat (3) begin
      @(negedge clk_i);
      chk("drop_wake", wake, 16'h0000);
      chk("drop_busy", busy, 0);
    end
`ifdef MEMPOOL_WAKEUP_STATS_EN
    chk("drop_cnt_two", drop_cnt, 32'd2);
`endif

    // Single request to core 5
    send(32'd5);
    chk("single_c1_wake", wake, 16'h0000);
    chk("single_c1_busy", busy, 1);
    @(negedge clk_i);
    chk("single_c2_wake", wake, 16'h0020);
    @(negedge clk_i);
    chk("single_c3_wake", wake, 16'h0000);
    chk("single_c3_busy", busy, 0);

    // Broadcast sweep
    send(32'hFFFF_FFFF);
    chk("bcast_c1_ready", ready, 0);
    chk("bcast_c1_wake", wake, 16'h0000);
    for (int g = 0; g < 4; g++) begin
      @(negedge clk_i);
      chk("bcast_grp_wake", wake, bc_pat[g]);
      chk("bcast_grp_ready", ready, (g == 3) ? 1 : 0);
    end
    @(negedge clk_i);
    chk("bcast_end_wake", wake, 16'h0000);

    // Re-request core 2 while its group is being emitted: set wins
    valid = 1'b1; target = 32'd2;
    @(posedge clk_i); @(negedge clk_i);
    @(posedge clk_i); @(negedge clk_i);
    valid = 1'b0;
    chk("rereq_c2_wake", wake, 16'h0004);
    @(negedge clk_i);
    chk("rereq_c3_wake", wake, 16'h0004);
    @(negedge clk_i);
    chk("rereq_c4_busy", busy, 0);

    // Reset in the middle of a broadcast
    send(32'hFFFF_FFFF);
    @(negedge clk_i);
    chk("rst_bcast_pre_wake", wake, 16'h000F);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_bcast_wake", wake, 16'h0000);
    chk("rst_bcast_busy", busy, 0);
    chk("rst_bcast_ready", ready, 1);
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);

    // Back-to-back requests 1, 9, 13 with rr_ptr at 0
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        valid = 1'b1;
        target = t4_tgt[i];
      end else begin
        valid = 1'b0;
      end
      if (i >= 2) chk("b2b_pulse", wake, t4_exp[i-2]);
      @(posedge clk_i); @(negedge clk_i);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_i);
      if (n == 1500) begin
        #2 rst_ni = 1'b0;
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
      end
      if (!(valid && !ready)) begin
        valid = ($urandom_range(0, 99) < 40);
        r = $urandom_range(0, 9);
        if (r < 7) target = $urandom_range(0, NC - 1);
        else if (r < 8) target = 32'hFFFF_FFFF;
        else target = $urandom_range(NC, 32'hFFFF_FFFE);
      end
      stats_clr = ($urandom_range(0, 99) == 0);
    end
    valid = 1'b0;
    stats_clr = 1'b0;
    repeat (10) @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mempool_wakeup_ctrl.md
Name: mempool_wakeup_ctrl

Overview:
Sequences wake-up pulses into the MemPool cluster's per-core wake_up_i vector, which is currently tied to zero.
- Accepts wake-up requests (single core or broadcast) over a valid/ready handshake from the control-register side.
- Tracks per-core pending bits.
- Emits registered one-cycle pulses, one core group per cycle, so all cores never wake in the same cycle.
- Sits beside the cluster top; wake_up_o drives the cluster's wake_up_i.

Parameters:
- NumCores, 256, number of cores / width of wake_up_o.
- NumGroups, 4, number of pulse groups; NumCores % NumGroups == 0 (elaboration assertion).
- GroupSize, NumCores/NumGroups, derived, do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- wake_req_valid_i  in  1  request valid.
- wake_req_ready_o  out  1  request ready.
- wake_req_target_i  in  32  target core id; 32'hFFFF_FFFF = broadcast.
- wake_up_o  out  NumCores  per-core wake pulse, registered.
- busy_o  out  1  pulses outstanding.

Behaviour:
- Reset (async, rst_ni low): state IDLE, pending='0, rr_ptr=0, grp_cnt=0, wake_up_o='0. Reset mid-broadcast or with pending bits discards all work.
- FSM states:
  - IDLE: wake_req_ready_o=1. Handshake fires on valid&ready; target is sampled that cycle.
  - BCAST: wake_req_ready_o=0.
- Accepted target < NumCores:
  - pending[target] set at the next edge.
  - Repeat requests for an already-pending core merge; no extra pulse.
- Accepted target == all-ones:
  - Go to BCAST next cycle with grp_cnt=0.
  - In BCAST each cycle: register wake_up_o = mask of group grp_cnt; clear pending bits of that group; grp_cnt++.
  - When grp_cnt == NumGroups-1 is issued, return to IDLE.
  - Timing: broadcast accepted in cycle 0 -> group g pulses in cycle 2+g -> ready high again in cycle 1+NumGroups.
- Accepted target in [NumCores, all-ones): accepted (ready stays 1) and dropped; no state change.
- Pending scheduling, in IDLE only:
  - Search groups from rr_ptr upward, cyclically, for the first group with any pending bit.
  - Register wake_up_o = that group's pending bits; clear them; rr_ptr = sel+1 mod NumGroups.
  - No group pending: wake_up_o='0, rr_ptr unchanged.
  - In BCAST, pending bits are not scheduled separately; the broadcast subsumes them.
- Latency: single request accepted cycle 0 -> pending in cycle 1 -> earliest pulse cycle 2. Worst case cycle 1+NumGroups when other groups are ahead in rr order.
- Simultaneous set and clear of the same pending bit (request accepted in the cycle its group is emitted): set wins. The core pulses again later; the request is never lost.
- Outputs and pulse width:
  - wake_up_o is high for exactly one cycle per emission; bits outside the selected group are 0.
  - busy_o = (state != IDLE) | (|pending), combinational from registers.

Optional Feature:
- Macro MEMPOOL_WAKEUP_STATS_EN.
- When defined, adds ports:
  - pulse_cnt_o, out, 32: number of cycles with wake_up_o != 0.
  - drop_cnt_o, out, 32: out-of-range requests dropped.
  - stats_clr_i, in, 1: synchronous clear; clear wins over a same-cycle increment.
- Counters reset to 0 and wrap at 2^32.
- When undefined: ports absent, no counter logic; all other behaviour identical.

Decomposition:
- mempool_pkg additions:
  - WakeupBroadcastId = 32'hFFFF_FFFF.
  - typedef enum logic {WakeIdle, WakeBcast} wake_state_e.
- Sub-module mempool_wakeup_grp_sel: combinational round-robin group picker.
  - Inputs: per-group any-pending vector, rr_ptr.
  - Outputs: sel index, sel_valid.
  - Implemented via a rotated leading-zero count.

Test Plan:
(NumCores=16, NumGroups=4)
1. Reset release, no requests -> wake_up_o=0, busy_o=0, ready=1 for 20 cycles.
2. Request target=5, accepted cycle 0 -> wake_up_o=16'h0020 in cycle 2 only; busy_o low from cycle 3.
3. Broadcast accepted cycle 0 -> wake_up_o = 16'h000F, 16'h00F0, 16'h0F00, 16'hF000 in cycles 2..5; ready=0 in cycles 1..4; ready=1 in cycle 5.
4. Requests 1, 9, 13 back-to-back in cycles 0..2 (rr_ptr=0) -> pulse patterns 0x0002, 0x0200, 0x2000 in cycles 2, 3, 4.
5. Request target=20, then target=32'h1234 -> both accepted, no pulses, busy_o=0; with MEMPOOL_WAKEUP_STATS_EN, drop_cnt_o=2.
6. Re-request core 2 in the cycle group 0 pulses for it -> second pulse 0x0004 within 4 cycles. Separately, rst_ni low during BCAST -> wake_up_o=0 immediately, pending cleared.
